// File: rtl/bip_dump_if.sv
// bip_dump_if: handshake/bus bundle between the dump scheduler, the core snapshot, the data RAM and the serial Interface
// Ports: start/pc/acc/cycles carry the request and the core state; mem_addr/mem_rdata form the RAM read port;
//        data_out/wr/tx_done handle the word transfer to the Interface; busy/done report dump status.
interface bip_dump_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] cycles;
    logic [DATA_W-1:0] mem_rdata;
    logic              tx_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] data_out;
    logic              wr;
    logic              busy;
    logic              done;
    modport master (
        output start, pc, acc, cycles, mem_rdata, tx_done,
        input  mem_addr, data_out, wr, busy, done
    );
    modport slave (
        input  start, pc, acc, cycles, mem_rdata, tx_done,
        output mem_addr, data_out, wr, busy, done
    );
endinterface

// File: rtl/bip_dump_scheduler.sv
// bip_dump_scheduler: sequences a debug dump (header, PC/ACC/CYCLES snapshot, N_MEM RAM words) to the serial Interface
// Ports: clk, reset (sync, active-high); bus (slave side of bip_dump_if): start/pc/acc/cycles in,
//        mem_addr out / mem_rdata in, data_out/wr out with tx_done in, busy/done out.
module bip_dump_scheduler #(
    parameter int              DATA_W = 16,
    parameter int              ADDR_W = 11,
    parameter int              N_MEM  = 16,
    parameter logic [DATA_W-1:0] HEADER = 16'hA55A
) (
    input logic       clk,
    input logic       reset,
    bip_dump_if.slave bus
);
    localparam int LAST  = N_MEM + 3;
    localparam int IDX_W = $clog2(LAST + 1);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_FIN} state_t;
    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              rd_wait;
    logic [ADDR_W-1:0] pc_s;
    logic [DATA_W-1:0] acc_s;
    logic [DATA_W-1:0] cyc_s;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] reg_word;
    logic              wr;
    logic              busy;
    logic              done;
    logic              is_mem;
    assign is_mem = idx >= IDX_W'(4);
    always_comb reg_word = idx == '0          ? HEADER :
                           idx == IDX_W'(1)   ? DATA_W'(pc_s) :
                           idx == IDX_W'(2)   ? acc_s : cyc_s;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            rd_wait  <= 1'b0;
            pc_s     <= '0;
            acc_s    <= '0;
            cyc_s    <= '0;
            mem_addr <= '0;
            data_out <= '0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    pc_s     <= bus.pc;
                    acc_s    <= bus.acc;
                    cyc_s    <= bus.cycles;
                    idx      <= '0;
                    mem_addr <= '0;
                    rd_wait  <= 1'b0;
                    busy     <= 1'b1;
                    state    <= S_LOAD;
                end
                // RAM words spend one extra LOAD cycle so mem_rdata reflects the address set on entry
                S_LOAD: if (is_mem && !rd_wait) begin
                    rd_wait <= 1'b1;
                end else begin
                    data_out <= is_mem ? bus.mem_rdata : reg_word;
                    wr       <= 1'b1;
                    rd_wait  <= 1'b0;
                    state    <= S_SEND;
                end
                S_SEND: state <= S_WAIT;
                S_WAIT: if (bus.tx_done) begin
                    if (idx == IDX_W'(LAST)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        idx <= idx + 1'b1;
                        // next word idx+1 maps to RAM address idx-3 once past the snapshot words
                        if (idx >= IDX_W'(3)) mem_addr <= ADDR_W'(idx - IDX_W'(3));
                        state <= S_LOAD;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    assign bus.mem_addr = mem_addr;
    assign bus.data_out = data_out;
    assign bus.wr       = wr;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_bip_dump_scheduler.sv
// tb_bip_dump_scheduler: directed checks of dump order, latency, snapshot freeze, ignored inputs and mid-dump reset
module tb_bip_dump_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    bip_dump_if #(.DATA_W(16), .ADDR_W(11)) bus ();
    bip_dump_scheduler #(.DATA_W(16), .ADDR_W(11), .N_MEM(4), .HEADER(16'hA55A)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    logic [15:0] ram   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [15:0] exp_w [8] = '{16'hA55A, 16'h007F, 16'h1234, 16'h0042,
                               16'h0001, 16'h0002, 16'h0003, 16'h0004};
    always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr[1:0]];
    int wr_count = 0;
    int done_count = 0;
    always @(negedge clk) begin
        if (bus.wr) wr_count++;
        if (bus.done) done_count++;
    end
    int pass_n = 0;
    int total_n = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic wait_wr(output logic [15:0] d, output logic ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.wr) begin
                ok = 1'b1;
                d  = bus.data_out;
                break;
            end
            @(negedge clk);
        end
    endtask
    task automatic pulse_tx();
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask
    task automatic pulse_start();
        bus.pc     = 11'h07F;
        bus.acc    = 16'h1234;
        bus.cycles = 16'h0042;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask
    // mode 0 plain, 1 ACC changes after accept, 2 START pulses and extra TX_DONE around word 2,
    // 3 TX_DONE coincident with every WR
    task automatic do_dump(input int mode);
        int w0;
        int d0;
        logic [15:0] d;
        logic ok;
        w0 = wr_count;
        d0 = done_count;
        pulse_start();
        if (mode == 1) bus.acc = 16'hFFFF;
        @(negedge clk);
        chk($sformatf("m%0d_first_wr_latency", mode), 32'(bus.wr), 1);
        for (int k = 0; k < 8; k++) begin
            wait_wr(d, ok);
            chk($sformatf("m%0d_wr_seen%0d", mode, k), 32'(ok), 1);
            chk($sformatf("m%0d_word%0d", mode, k), 32'(d), 32'(exp_w[k]));
            if (mode == 3) begin
                pulse_tx();
                repeat (5) @(negedge clk);
                chk($sformatf("m3_no_repeat_wr%0d", k), 32'(wr_count - w0), 32'(k + 1));
            end
            repeat (19) @(negedge clk);
            if (mode == 2 && k == 2) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            chk($sformatf("m%0d_data_held%0d", mode, k), 32'(bus.data_out), 32'(exp_w[k]));
            pulse_tx();
            if (mode == 2 && k == 2) pulse_tx();
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("m%0d_done_seen", mode), 32'(ok), 1);
        @(negedge clk);
        chk($sformatf("m%0d_busy_low", mode), 32'(bus.busy), 0);
        chk($sformatf("m%0d_done_one_cycle", mode), 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        chk($sformatf("m%0d_done_count", mode), 32'(done_count - d0), 1);
        chk($sformatf("m%0d_wr_count", mode), 32'(wr_count - w0), 8);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [15:0] d;
        logic ok;
        int d0;
        bus.start   = 1'b0;
        bus.pc      = '0;
        bus.acc     = '0;
        bus.cycles  = '0;
        bus.tx_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_wr", 32'(bus.wr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        reset = 1'b0;
        @(negedge clk);
        do_dump(0);
        chk("mem_addr_hold", 32'(bus.mem_addr), 3);
        do_dump(1);
        do_dump(2);
        d0 = done_count;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            wait_wr(d, ok);
            chk($sformatf("rst_pre_word%0d", k), 32'(d), 32'(exp_w[k]));
            repeat (19) @(negedge clk);
            pulse_tx();
        end
        wait_wr(d, ok);
        chk("rst_pre_word5", 32'(d), 32'(exp_w[5]));
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_wr", 32'(bus.wr), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_count - d0), 0);
        do_dump(0);
        do_dump(3);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
